// File: rtl/ysyx_22050133_burst_mem_resp.sv
// Memory-side responder for the cache burst port: one address phase, then a
// read or write burst against an internal word array with paced read beats.
module ysyx_22050133_burst_mem_resp #(
  parameter int unsigned RW_DATA_WIDTH = 64,
  parameter int unsigned RW_ADDR_WIDTH = 32,
  parameter logic [RW_ADDR_WIDTH-1:0] MEM_BASE = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned BEAT_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rw_addr_valid_i,
  output logic                     rw_addr_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0] rw_addr_i,
  input  logic                     rw_we_i,
  input  logic [7:0]               rw_len_i,
  input  logic [2:0]               rw_size_i,
  input  logic [1:0]               rw_burst_i,
  input  logic                     rw_if_i,
  input  logic                     w_data_valid_i,
  output logic                     w_data_ready_o,
  input  logic [RW_DATA_WIDTH-1:0] w_data_i,
  output logic                     r_data_valid_o,
  input  logic                     r_data_ready_i,
  output logic [RW_DATA_WIDTH-1:0] r_data_o,
  output logic                     err_o
);

  localparam int unsigned AW    = RW_ADDR_WIDTH;
  localparam int unsigned DW    = RW_DATA_WIDTH;
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned LAT_W = (BEAT_LAT > 1) ? $clog2(BEAT_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(BEAT_LAT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ_WAIT, READ_VALID, DONE} state_t;

  state_t state, state_next;

  logic [AW-1:0]    addr_q;
  logic [7:0]       len_q;
  logic [1:0]       sz_q;
  logic [1:0]       burst_q;
  logic             if_q;
  logic [7:0]       beat_q;
  logic [LAT_W-1:0] lat_q;
  logic             err_q;

  logic [DW-1:0] mem [MEM_WORDS];

  logic [AW-4:0]    off_w;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [AW-1:0]    step, incr, win_mask, addr_next;
  logic             wrap_ok;
  logic [7:0]       size_be, wr_be;
  logic [DW-1:0]    wr_data, rd_shift, size_mask;
  logic             mem_we;

  // Word offset from the base; MEM_BASE is assumed word aligned.
  always_comb begin
    off_w    = addr_q[AW-1:3] - MEM_BASE[AW-1:3];
    in_range = (addr_q >= MEM_BASE) && (off_w < (AW-3)'(MEM_WORDS));
    word_idx = off_w[IDX_W-1:0];
  end

  always_comb begin
    step     = AW'(1) << sz_q;
    incr     = addr_q + step;
    wrap_ok  = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    win_mask = (({{(AW-8){1'b0}}, len_q} + AW'(1)) << sz_q) - AW'(1);
    unique case (burst_q)
      2'd0:    addr_next = addr_q;
      2'd2:    addr_next = wrap_ok ? ((addr_q & ~win_mask) | (incr & win_mask)) : incr;
      default: addr_next = incr;
    endcase
  end

  // Byte lanes past the word end fall off the 8-bit enable and the shifted data.
  always_comb begin
    unique case (sz_q)
      2'd0:    begin size_be = 8'h01; size_mask = DW'(64'h0000_0000_0000_00FF); end
      2'd1:    begin size_be = 8'h03; size_mask = DW'(64'h0000_0000_0000_FFFF); end
      2'd2:    begin size_be = 8'h0F; size_mask = DW'(64'h0000_0000_FFFF_FFFF); end
      default: begin size_be = 8'hFF; size_mask = '1; end
    endcase
    wr_be    = size_be << addr_q[2:0];
    wr_data  = w_data_i << {addr_q[2:0], 3'b000};
    rd_shift = mem[word_idx] >> {addr_q[2:0], 3'b000};
    mem_we   = (state == WRITE) && w_data_valid_i && in_range && !if_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (rw_addr_valid_i) state_next = rw_we_i ? WRITE : READ_WAIT;
      WRITE:      if (w_data_valid_i && beat_q == len_q) state_next = DONE;
      READ_WAIT:  if (lat_q == '0) state_next = READ_VALID;
      READ_VALID: if (r_data_ready_i) state_next = (beat_q == len_q) ? DONE : READ_WAIT;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    rw_addr_ready_o = (state == IDLE);
    w_data_ready_o  = (state == WRITE);
    r_data_valid_o  = (state == READ_VALID);
    r_data_o        = '0;
    if (state == READ_VALID && in_range) r_data_o = rd_shift & size_mask;
    err_o           = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      sz_q    <= '0;
      burst_q <= '0;
      if_q    <= 1'b0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (rw_addr_valid_i) begin
          addr_q  <= rw_addr_i;
          len_q   <= rw_len_i;
          sz_q    <= (rw_size_i > 3'd3) ? 2'd3 : rw_size_i[1:0];
          burst_q <= rw_burst_i;
          if_q    <= rw_if_i;
          beat_q  <= '0;
          err_q   <= 1'b0;
          lat_q   <= LAT_RELOAD;
        end
        WRITE: if (w_data_valid_i) begin
          err_q  <= err_q | !in_range;
          addr_q <= addr_next;
          beat_q <= beat_q + 8'd1;
        end
        READ_WAIT: if (lat_q != '0) lat_q <= lat_q - LAT_W'(1);
        READ_VALID: if (r_data_ready_i) begin
          err_q  <= err_q | !in_range;
          addr_q <= addr_next;
          beat_q <= beat_q + 8'd1;
          lat_q  <= LAT_RELOAD;
        end
        default: ;
      endcase
    end
  end

endmodule
